branch_compare_seq: RTL

//  Parametrised, multi-cycle branch comparator for the EX stage. Accepts two WIDTH-bit operands plus a

---
 rtl/branch_compare_seq.sv | 138 +++++++++++++
 1 files changed

// File: rtl/branch_compare_seq.sv
// Multi-cycle branch comparator: scans operands CHUNK bits per cycle from the MSB down.
// Define CMP_EARLY_EXIT_EN to finish at the first differing chunk instead of a constant-time scan.
module branch_compare_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       funct3,
    input  logic             i_flush,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_a_lt_b,
    output logic             o_a_eq_b,
    output logic             o_taken,
    output logic             o_illegal
);
    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned IDXW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] IDX_TOP = IDXW'(NCHUNK - 1);
    localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

    if (WIDTH % CHUNK != 0) begin : g_width_check
        $error("WIDTH must be a multiple of CHUNK");
    end

    typedef enum logic [1:0] {StIdle, StCmp, StDone} state_e;

    state_e          state_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [2:0]      f3_q;
    logic [IDXW-1:0] idx_q;

    logic [CHUNK-1:0] ca, cb;
    logic             diff, chunk_lt;
    logic             done_now, fin_lt, fin_eq, fin_taken, fin_illegal;

`ifndef CMP_EARLY_EXIT_EN
    // First differing chunk decides lt; later chunks cannot override it.
    logic found_q, lt_q;
`endif

    assign o_ready = (state_q == StIdle);

    always_comb begin
        ca       = a_q[int'(idx_q)*CHUNK +: CHUNK];
        cb       = b_q[int'(idx_q)*CHUNK +: CHUNK];
        diff     = (ca != cb);
        chunk_lt = (ca < cb);
`ifdef CMP_EARLY_EXIT_EN
        done_now = diff || (idx_q == '0);
        fin_lt   = diff && chunk_lt;
        fin_eq   = !diff;
`else
        done_now = (idx_q == '0);
        fin_lt   = found_q ? lt_q : (diff && chunk_lt);
        fin_eq   = !found_q && !diff;
`endif
        fin_illegal = (f3_q[2:1] == 2'b01);
        case (f3_q)
            3'b000:         fin_taken = fin_eq;
            3'b001:         fin_taken = !fin_eq;
            3'b100, 3'b110: fin_taken = fin_lt;
            3'b101, 3'b111: fin_taken = !fin_lt;
            default:        fin_taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            a_q       <= '0;
            b_q       <= '0;
            f3_q      <= '0;
            idx_q     <= IDX_TOP;
            o_valid   <= 1'b0;
            o_a_lt_b  <= 1'b0;
            o_a_eq_b  <= 1'b0;
            o_taken   <= 1'b0;
            o_illegal <= 1'b0;
`ifndef CMP_EARLY_EXIT_EN
            found_q   <= 1'b0;
            lt_q      <= 1'b0;
`endif
        end else if (i_flush) begin
            state_q <= StIdle;
            idx_q   <= IDX_TOP;
            o_valid <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (i_valid) begin
                        // Flipping the sign bits maps signed order onto unsigned order.
                        a_q     <= funct3[1] ? a : (a ^ MSB_MASK);
                        b_q     <= funct3[1] ? b : (b ^ MSB_MASK);
                        f3_q    <= funct3;
                        idx_q   <= IDX_TOP;
                        state_q <= StCmp;
`ifndef CMP_EARLY_EXIT_EN
                        found_q <= 1'b0;
                        lt_q    <= 1'b0;
`endif
                    end
                end
                StCmp: begin
                    if (done_now) begin
                        o_a_lt_b  <= fin_lt;
                        o_a_eq_b  <= fin_eq;
                        o_taken   <= fin_taken;
                        o_illegal <= fin_illegal;
                        o_valid   <= 1'b1;
                        state_q   <= StDone;
                    end else begin
                        idx_q <= idx_q - 1'b1;
`ifndef CMP_EARLY_EXIT_EN
                        if (!found_q && diff) begin
                            found_q <= 1'b1;
                            lt_q    <= chunk_lt;
                        end
`endif
                    end
                end
                StDone: begin
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        idx_q   <= IDX_TOP;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule
